// File: rtl/octal_ram_op_sequencer.sv
// Octal RAM command sequencer: runs the bring-up ops, then turns host requests into
// op-code/done handshakes with idle gaps, a per-op watchdog and read-data return.
module octal_ram_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned IDLE_GAP       = 2,
  parameter bit          BOOT_VERIFY    = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq_Valid,
  output logic        oReq_Ready,
  input  logic        iReq_Wr,
  input  logic [31:0] iReq_Addr,
  input  logic [15:0] iReq_Data,
  output logic        oRsp_Valid,
  output logic        oRsp_Wr,
  output logic [15:0] oRsp_Data,
  output logic        oInit_Done,
  output logic        oFault,
  output logic [2:0]  oFault_Op,
  output logic [2:0]  oOp_Code,
  input  logic        iOp_Done,
  output logic [31:0] oAddress,
  output logic [15:0] oData,
  input  logic [15:0] iData
);

  typedef enum logic [2:0] {
    StBootRst, StBootMrw, StBootMrr, StGap, StReady, StWr, StRd, StFault
  } state_e;

  localparam logic [15:0] WdLast  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  GapLast = 4'(IDLE_GAP - 1);

  state_e      state_q, state_d, gap_next_q, gap_next_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] wd_q, wd_d;
  logic [2:0]  op_code_q, op_code_d, fault_op_q, fault_op_d;
  logic        ready_q, ready_d, rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
  logic        init_done_q, init_done_d, fault_q, fault_d, req_wr_q, req_wr_d;
  logic [15:0] rsp_data_q, rsp_data_d, data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        op_active, op_done, wd_expired;

  function automatic logic [2:0] op_code_of(state_e s);
    case (s)
      StBootRst: op_code_of = 3'd1;
      StBootMrw: op_code_of = 3'd2;
      StBootMrr: op_code_of = 3'd3;
      StWr:      op_code_of = 3'd4;
      StRd:      op_code_of = 3'd5;
      default:   op_code_of = 3'd0;
    endcase
  endfunction

  // An op is live only once its code is visible; this keeps the reset-exit cycle out of it.
  assign op_active  = (op_code_q != 3'd0);
  assign op_done    = op_active && iOp_Done;
  assign wd_expired = op_active && (wd_q == WdLast);

  always_comb begin
    state_d     = state_q;
    gap_next_d  = gap_next_q;
    gap_cnt_d   = gap_cnt_q;
    wd_d        = op_active ? wd_q + 16'd1 : wd_q;
    fault_d     = fault_q;
    fault_op_d  = fault_op_q;
    rsp_valid_d = 1'b0;
    rsp_wr_d    = rsp_wr_q;
    rsp_data_d  = rsp_data_q;
    addr_d      = addr_q;
    data_d      = data_q;
    req_wr_d    = req_wr_q;

    unique case (state_q)
      StBootRst, StBootMrw, StBootMrr, StWr, StRd: begin
        if (op_done) begin
          state_d   = StGap;
          gap_cnt_d = 4'd0;
          if (state_q == StBootRst) begin
            gap_next_d = StBootMrw;
          end else if (state_q == StBootMrw && BOOT_VERIFY) begin
            gap_next_d = StBootMrr;
          end else begin
            gap_next_d = StReady;
          end
          if (state_q == StWr || state_q == StRd) begin
            rsp_valid_d = 1'b1;
            rsp_wr_d    = req_wr_q;
            rsp_data_d  = req_wr_q ? 16'h0000 : iData;
          end
        end else if (wd_expired) begin
          state_d    = StFault;
          fault_d    = 1'b1;
          fault_op_d = op_code_q;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = gap_next_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StReady: begin
        if (iReq_Valid && ready_q) begin
          state_d  = iReq_Wr ? StWr : StRd;
          addr_d   = iReq_Addr;
          data_d   = iReq_Data;
          req_wr_d = iReq_Wr;
        end
      end
      StFault: begin
      end
    endcase

    if (state_d != state_q) begin
      wd_d = 16'd0;
    end
    op_code_d   = op_code_of(state_d);
    ready_d     = (state_d == StReady);
    init_done_d = init_done_q | ready_d;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= StBootRst;
      gap_next_q  <= StBootRst;
      gap_cnt_q   <= 4'd0;
      wd_q        <= 16'd0;
      op_code_q   <= 3'd0;
      fault_op_q  <= 3'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_data_q  <= 16'h0000;
      init_done_q <= 1'b0;
      fault_q     <= 1'b0;
      req_wr_q    <= 1'b0;
      addr_q      <= 32'h0;
      data_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      gap_next_q  <= gap_next_d;
      gap_cnt_q   <= gap_cnt_d;
      wd_q        <= wd_d;
      op_code_q   <= op_code_d;
      fault_op_q  <= fault_op_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
      fault_q     <= fault_d;
      req_wr_q    <= req_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign oReq_Ready = ready_q;
  assign oRsp_Valid = rsp_valid_q;
  assign oRsp_Wr    = rsp_wr_q;
  assign oRsp_Data  = rsp_data_q;
  assign oInit_Done = init_done_q;
  assign oFault     = fault_q;
  assign oFault_Op  = fault_op_q;
  assign oOp_Code   = op_code_q;
  assign oAddress   = addr_q;
  assign oData      = data_q;

endmodule

// File: tb/tb_octal_ram_op_sequencer.sv
// Randomized bench for octal_ram_op_sequencer: operator model, host driver, response monitor.
module tb_octal_ram_op_sequencer;

  localparam int TO     = 64;
  localparam int GAP    = 2;
  localparam int BV     = 1;
  localparam int BOOT_D = 5;

  logic        iClk, iRst, iReq_Valid, iReq_Wr, iOp_Done;
  logic [31:0] iReq_Addr;
  logic [15:0] iReq_Data, iData;
  logic        oReq_Ready, oRsp_Valid, oRsp_Wr, oInit_Done, oFault;
  logic [15:0] oRsp_Data, oData;
  logic [2:0]  oFault_Op, oOp_Code;
  logic [31:0] oAddress;

  octal_ram_op_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .IDLE_GAP      (GAP),
    .BOOT_VERIFY   (1'(BV))
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReq_Valid(iReq_Valid),
    .oReq_Ready(oReq_Ready),
    .iReq_Wr   (iReq_Wr),
    .iReq_Addr (iReq_Addr),
    .iReq_Data (iReq_Data),
    .oRsp_Valid(oRsp_Valid),
    .oRsp_Wr   (oRsp_Wr),
    .oRsp_Data (oRsp_Data),
    .oInit_Done(oInit_Done),
    .oFault    (oFault),
    .oFault_Op (oFault_Op),
    .oOp_Code  (oOp_Code),
    .iOp_Done  (iOp_Done),
    .oAddress  (oAddress),
    .oData     (oData),
    .iData     (iData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Operator model controls (written by the main process only)
  int          op_delay   = BOOT_D;
  bit          rand_delay = 1'b0;
  bit          never_rd   = 1'b0;
  bit          force_rd   = 1'b0;
  logic [15:0] force_val  = 16'h0;
  int          stray_req  = 0;

  // Operator model records (written by the operator process only)
  logic [50:0] op_q[$];
  logic [15:0] rdw_q[$];
  int          last_done_cyc = -10;

  initial begin
    int opc, cur_delay, stray_ack;
    logic [15:0] w;
    opc = 0; cur_delay = 0; stray_ack = 0;
    iOp_Done = 1'b0;
    iData    = 16'h0;
    forever begin
      @(negedge iClk);
      iOp_Done = 1'b0;
      iData    = 16'($urandom);
      if (stray_req != stray_ack) begin
        iOp_Done  = 1'b1;
        stray_ack = stray_req;
      end
      if (iRst || oOp_Code == 3'd0) begin
        opc = 0;
      end else begin
        if (opc == 0) cur_delay = rand_delay ? int'($urandom_range(0, 8)) : op_delay;
        if (opc == cur_delay && !(never_rd && oOp_Code == 3'd5)) begin
          iOp_Done = 1'b1;
          if (oOp_Code == 3'd5) begin
            w = force_rd ? force_val : 16'($urandom);
            iData = w;
            rdw_q.push_back(w);
          end
          if (oOp_Code >= 3'd4) begin
            op_q.push_back({oOp_Code, oAddress, oData});
            last_done_cyc = cyc;
          end
        end
        opc++;
      end
    end
  end

  // Monitor: responses, response latency, zero-code gaps, ready return delay
  logic [16:0] rsp_q[$];
  int          lat_q[$];
  int          gap_q[$];
  int          rdy_q[$];

  initial begin
    int zrun, rsp_cyc;
    bit seen_op, rsp_pend, prev_rdy;
    zrun = 0; rsp_cyc = 0; seen_op = 0; rsp_pend = 0; prev_rdy = 0;
    forever begin
      @(negedge iClk);
      if (iRst) begin
        zrun = 0; seen_op = 0; rsp_pend = 0; prev_rdy = 0;
      end else begin
        if (oOp_Code == 3'd0) begin
          zrun++;
        end else begin
          if (seen_op && zrun != 0) gap_q.push_back(zrun);
          seen_op = 1;
          zrun    = 0;
        end
        if (oRsp_Valid) begin
          rsp_q.push_back({oRsp_Wr, oRsp_Data});
          lat_q.push_back(cyc - last_done_cyc);
          rsp_pend = 1;
          rsp_cyc  = cyc;
        end
        if (oReq_Ready && !prev_rdy && rsp_pend) begin
          rdy_q.push_back(cyc - rsp_cyc);
          rsp_pend = 0;
        end
        prev_rdy = oReq_Ready;
      end
    end
  end

  int lat_i = 0, gap_i = 0, rdy_i = 0;

  task automatic check_mon();
    while (lat_i < lat_q.size()) begin
      chk("rsp_latency", 64'(lat_q[lat_i]), 64'(1));
      lat_i++;
    end
    while (gap_i < gap_q.size()) begin
      chk("gap_min_len", 64'(gap_q[gap_i] >= GAP), 64'(1));
      gap_i++;
    end
    while (rdy_i < rdy_q.size()) begin
      chk("ready_return", 64'(rdy_q[rdy_i]), 64'(GAP));
      rdy_i++;
    end
  endtask

  task automatic reset_boot();
    int exp_q[$];
    iRst = 1'b1;
    iReq_Valid = 1'b0;
    repeat (2) @(negedge iClk);
    chk("rst_ctl", 64'({oReq_Ready, oRsp_Valid, oRsp_Wr, oInit_Done, oFault, oFault_Op,
                        oOp_Code}), 64'(0));
    chk("rst_dat", {oRsp_Data, oAddress, oData}, 64'(0));
    rand_delay = 1'b0;
    op_delay   = BOOT_D;
    for (int o = 1; o <= 3; o++) begin
      if (o == 3 && BV == 0) continue;
      repeat (BOOT_D + 1) exp_q.push_back(o);
      repeat (GAP) exp_q.push_back(0);
    end
    iRst = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge iClk);
      chk("boot_seq", 64'(oOp_Code), 64'(exp_q[j]));
    end
    chk("boot_init_early", 64'(oInit_Done), 64'(0));
    @(negedge iClk);
    chk("boot_ready", 64'(oReq_Ready), 64'(1));
    chk("boot_init_done", 64'(oInit_Done), 64'(1));
    chk("boot_no_fault", 64'(oFault), 64'(0));
    check_mon();
  endtask

  logic        rq_wr[32];
  logic [31:0] rq_addr[32];
  logic [15:0] rq_data[32];

  task automatic run_reqs(input int n, input bit hold);
    int k, ri, ob, rb, db;
    logic [15:0] exp_rd;
    ob = op_q.size(); rb = rsp_q.size(); db = rdw_q.size();
    for (int i = 0; i < n; i++) begin
      if (!hold) begin
        iReq_Valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge iClk);
      end
      iReq_Valid = 1'b1;
      iReq_Wr    = rq_wr[i];
      iReq_Addr  = rq_addr[i];
      iReq_Data  = rq_data[i];
      k = 0;
      while (!oReq_Ready && k < 400) begin
        @(negedge iClk);
        k++;
      end
      chk("accept_wait", 64'(oReq_Ready), 64'(1));
      if (!oReq_Ready) break;
      @(negedge iClk);
      chk("op_start", 64'(oOp_Code), rq_wr[i] ? 64'(4) : 64'(5));
      chk("ready_fall", 64'(oReq_Ready), 64'(0));
      chk("op_addr", 64'(oAddress), 64'(rq_addr[i]));
      chk("op_data", 64'(oData), 64'(rq_data[i]));
      if (!hold) iReq_Valid = 1'b0;
    end
    iReq_Valid = 1'b0;
    k = 0;
    while (rsp_q.size() < rb + n && k < 2000) begin
      @(negedge iClk);
      k++;
    end
    repeat (GAP + 3) @(negedge iClk);
    chk("rsp_count", 64'(rsp_q.size() - rb), 64'(n));
    chk("op_count", 64'(op_q.size() - ob), 64'(n));
    ri = db;
    for (int i = 0; i < n; i++) begin
      if (ob + i < op_q.size()) begin
        chk("done_code", 64'(op_q[ob+i][50:48]), rq_wr[i] ? 64'(4) : 64'(5));
        chk("done_addr", 64'(op_q[ob+i][47:16]), 64'(rq_addr[i]));
        chk("done_data", 64'(op_q[ob+i][15:0]), 64'(rq_data[i]));
      end
      exp_rd = 16'h0;
      if (!rq_wr[i]) begin
        if (ri < rdw_q.size()) exp_rd = rdw_q[ri];
        ri++;
      end
      if (rb + i < rsp_q.size()) begin
        chk("rsp_wr", 64'(rsp_q[rb+i][16]), 64'(rq_wr[i]));
        chk("rsp_data", 64'(rsp_q[rb+i][15:0]), 64'(exp_rd));
      end
    end
    check_mon();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int k, e, rb;
    iRst = 1'b1; iReq_Valid = 1'b0; iReq_Wr = 1'b0; iReq_Addr = 32'h0; iReq_Data = 16'h0;

    reset_boot();

    // Directed write then read of the same word
    rq_wr[0] = 1'b1; rq_addr[0] = 32'h0000_0100; rq_data[0] = 16'hA55A;
    run_reqs(1, 1'b0);
    force_rd = 1'b1; force_val = 16'h1987;
    rq_wr[0] = 1'b0; rq_addr[0] = 32'h0000_0100; rq_data[0] = 16'h0;
    run_reqs(1, 1'b0);
    chk("read_1987", 64'(oRsp_Data), 64'(16'h1987));
    force_rd = 1'b0;

    // Valid held across three queued requests
    rq_wr[0] = 1'b1; rq_addr[0] = 32'h0000_0200; rq_data[0] = 16'h1111;
    rq_wr[1] = 1'b0; rq_addr[1] = 32'h0000_0204; rq_data[1] = 16'h2222;
    rq_wr[2] = 1'b1; rq_addr[2] = 32'h0000_0208; rq_data[2] = 16'h3333;
    run_reqs(3, 1'b1);

    // Randomized traffic with random operator latency
    rand_delay = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 15; i++) begin
        rq_wr[i]   = 1'($urandom);
        rq_addr[i] = $urandom;
        rq_data[i] = 16'($urandom);
      end
      run_reqs(15, pass[0]);
    end
    rand_delay = 1'b0;
    op_delay   = BOOT_D;

    // Watchdog: operator never completes a read
    never_rd = 1'b1;
    rb = rsp_q.size();
    iReq_Valid = 1'b1; iReq_Wr = 1'b0; iReq_Addr = $urandom; iReq_Data = 16'($urandom);
    k = 0;
    while (!oReq_Ready && k < 100) begin
      @(negedge iClk);
      k++;
    end
    @(negedge iClk);
    e = cyc;
    iReq_Valid = 1'b0;
    chk("to_op_start", 64'(oOp_Code), 64'(5));
    k = 0;
    while (!oFault && k < TO + 50) begin
      @(negedge iClk);
      k++;
    end
    chk("to_fault_cycle", 64'(cyc - e), 64'(TO));
    chk("to_fault_op", 64'(oFault_Op), 64'(5));
    chk("to_code_zero", 64'(oOp_Code), 64'(0));
    chk("to_ready_low", 64'(oReq_Ready), 64'(0));
    iReq_Valid = 1'b1;
    stray_req++;
    repeat (6) @(negedge iClk);
    chk("to_no_rsp", 64'(rsp_q.size() - rb), 64'(0));
    chk("to_fault_sticky", 64'(oFault), 64'(1));
    chk("to_ready_stays", 64'(oReq_Ready), 64'(0));
    iReq_Valid = 1'b0;
    never_rd = 1'b0;

    // Reset clears the fault; then reset again in the middle of op 2
    iRst = 1'b1;
    @(negedge iClk);
    chk("rst_fault_clr", 64'(oFault), 64'(0));
    iRst = 1'b0;
    k = 0;
    while (oOp_Code != 3'd2 && k < 100) begin
      @(negedge iClk);
      k++;
    end
    chk("mid_reach_op2", 64'(oOp_Code), 64'(2));
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    chk("mid_code_zero", 64'(oOp_Code), 64'(0));
    chk("mid_outs_zero", 64'({oFault, oInit_Done, oReq_Ready, oRsp_Valid}), 64'(0));
    reset_boot();

    // Done arriving on the expiry cycle wins over the watchdog
    op_delay = TO - 1;
    rq_wr[0] = 1'b0; rq_addr[0] = $urandom; rq_data[0] = 16'($urandom);
    run_reqs(1, 1'b0);
    chk("exp_no_fault", 64'(oFault), 64'(0));
    rq_wr[0] = 1'b1;
    run_reqs(1, 1'b0);
    chk("exp_no_fault_wr", 64'(oFault), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
